ex_div: RTL and testbench
=========================

Name: ex_div

Overview:
- Multi-cycle radix-2 restoring divider for the EX stage, serving DIV and DIVU.
- Consumes the EX-stage operands and aluop that the ID/EX pipeline register delivers.
- Produces the 64-bit {remainder, quotient} result that EX writes to HI/LO.
- Raises a stall request while a division is in flight, so the pipeline controller holds IF–EX.

Parameters:
- DW, 32, operand width; the result is 2*DW.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DW.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- start_i  in  1  EX requests a division; held high until ready_o is seen.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  DW  dividend (EX op1 data).
- opdata2_i  in  DW  divisor (EX op2 data).
- annul_i  in  1  abort an in-flight division (exception or flush).
- result_o  out  2*DW  {remainder, quotient}, registered.
- ready_o  out  1  result valid, registered.
- stallreq_o  out  1  combinational; equals start_i & ~ready_o & ~annul_i.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FREE, result_o=0, ready_o=0, counter=0, internal dividend/divisor registers=0.
  - Reset asserted in any state aborts immediately; no partial result is ever output.
- States: FREE, BY_ZERO, ON, END.
- FREE:
  - start_i=1, annul_i=0, opdata2_i=0 → BY_ZERO.
  - start_i=1, annul_i=0, opdata2_i≠0 → ON. Load |op1|, |op2| (abs only when signed_i=1), counter=0, partial remainder=0. Latch the sign of op1, the sign of op2 and signed_i.
  - Otherwise stay in FREE; ready_o=0, result_o=0.
- BY_ZERO: next edge → END with result_o=0 and ready_o=1.
- ON:
  - annul_i=1 → FREE at the next edge, ready_o=0, result discarded.
  - Otherwise, each edge performs one shift/subtract step: partial remainder shifted left with the next dividend bit; if remainder ≥ divisor, subtract and set the quotient bit to 1, else 0. Counter increments.
  - On the edge that completes step DW (counter reaches DW): state→END.
    - Quotient negated if signed and the latched signs differ.
    - Remainder negated if signed and the dividend was negative.
    - result_o={rem, quo}, ready_o=1.
- END:
  - Holds result_o and ready_o=1 while start_i=1.
  - start_i=0 → FREE next edge: ready_o=0, result_o=0.
  - annul_i=1 → FREE next edge.
- Latency:
  - Start sampled at edge E0, then ON for edges E1..E32; ready_o first high after E32 (33 edges after start).
  - Divide-by-zero: ready_o high after E1.
- Operand stability:
  - Operands and signed_i are sampled only at the FREE→ON edge.
  - Changes to them during ON or END are ignored.
- Signed overflow: dividend 0x80000000 / divisor 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (the wrap-around result of the magnitude path, not trapped).
- Back-to-back divisions:
  - EX must drop start_i for at least one cycle (the END→FREE edge) before a new start is accepted.
  - If start_i stays high in END, no new division begins.
- Simultaneous start_i and annul_i in FREE: annul wins; stay in FREE.
- No X propagation: all outputs are defined in every state.

Test Plan:
- Unsigned basic: signed_i=0, op1=100, op2=7, start held → ready_o after 33 edges; result_o=64'h00000002_0000000E; stallreq_o=1 during E0..E32, then 0.
- Signed mixed: signed_i=1, op1=0xFFFFFFF9 (−7), op2=2 → result_o=64'hFFFFFFFF_FFFFFFFD (rem −1, quo −3). Also check op1=7, op2=0xFFFFFFFE → 64'h00000001_FFFFFFFD.
- Divide by zero: op2=0, start → ready_o=1 after 2 edges, result_o=0; drop start → next edge ready_o=0, state FREE.
- Annul mid-flight: start accepted, annul_i pulsed at edge E10 → FREE, ready_o never asserts. A new start (op1=0xFFFFFFFF unsigned, op2=1) then completes normally with quotient 0xFFFFFFFF, remainder 0.
- Async reset mid-division: rst driven low between edges at cycle 15 → result_o=0, ready_o=0 immediately, without a clock edge. After release, start is accepted from FREE.
- Held start in END: keep start_i high 5 cycles after ready → result_o stable and no restart; change opdata during ON → result unaffected. Edge case 0x80000000 / 0xFFFFFFFF signed → quo 0x80000000, rem 0.

Source files
------------

// File: rtl/ex_div_if.sv
// ex_div_if: EX-stage divider request/result bundle
interface ex_div_if #(
  parameter int DW = 32
);
  logic          start_i;
  logic          signed_i;
  logic [DW-1:0] opdata1_i;
  logic [DW-1:0] opdata2_i;
  logic          annul_i;
  logic [2*DW-1:0] result_o;
  logic          ready_o;
  logic          stallreq_o;
  modport master (
    output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );
  modport slave (
    input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/ex_div.sv
// ex_div: multi-cycle radix-2 restoring divider for DIV/DIVU in EX
module ex_div #(
  parameter int DW    = 32,
  parameter int CNT_W = 6
) (
  input logic     clk,
  input logic     rst,
  ex_div_if.slave bus
);
  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;
  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [DW-1:0]     dvd, dvd_nx;
  logic [DW-1:0]     dvr, dvr_nx;
  logic [DW-1:0]     rem, rem_nx;
  logic              neg1, neg1_nx, neg2, neg2_nx, sgn, sgn_nx;
  logic [2*DW-1:0]   result_nx;
  logic              ready_nx;
  logic [DW:0]       sh;
  logic              ge;
  logic [DW-1:0]     rem_step, quo_step, rem_fix, quo_fix, abs1, abs2;
  // dvd doubles as the quotient shift register: dividend bits leave at the top, quotient bits enter at the bottom
  assign sh       = {rem, dvd[DW-1]};
  assign ge       = sh >= {1'b0, dvr};
  assign rem_step = ge ? DW'(sh - {1'b0, dvr}) : sh[DW-1:0];
  assign quo_step = {dvd[DW-2:0], ge};
  assign quo_fix  = sgn & (neg1 ^ neg2) ? -quo_step : quo_step;
  assign rem_fix  = sgn & neg1 ? -rem_step : rem_step;
  assign abs1     = bus.signed_i & bus.opdata1_i[DW-1] ? -bus.opdata1_i : bus.opdata1_i;
  assign abs2     = bus.signed_i & bus.opdata2_i[DW-1] ? -bus.opdata2_i : bus.opdata2_i;
  assign bus.stallreq_o = bus.start_i & ~bus.ready_o & ~bus.annul_i;
  // next state, datapath step and registered-output values
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    dvd_nx    = dvd;
    dvr_nx    = dvr;
    rem_nx    = rem;
    neg1_nx   = neg1;
    neg2_nx   = neg2;
    sgn_nx    = sgn;
    result_nx = '0;
    ready_nx  = 1'b0;
    case (state)
      FREE: if (bus.start_i & ~bus.annul_i) begin
        state_nx = bus.opdata2_i == '0 ? BY_ZERO : ON;
        cnt_nx   = '0;
        rem_nx   = '0;
        dvd_nx   = abs1;
        dvr_nx   = abs2;
        neg1_nx  = bus.opdata1_i[DW-1];
        neg2_nx  = bus.opdata2_i[DW-1];
        sgn_nx   = bus.signed_i;
      end
      BY_ZERO: begin
        state_nx = END;
        ready_nx = 1'b1;
      end
      ON: if (bus.annul_i) state_nx = FREE;
      else begin
        cnt_nx = cnt + CNT_W'(1);
        dvd_nx = quo_step;
        rem_nx = rem_step;
        if (cnt == CNT_W'(DW - 1)) begin
          state_nx  = END;
          ready_nx  = 1'b1;
          result_nx = {rem_fix, quo_fix};
        end
      end
      END: if (bus.start_i & ~bus.annul_i) begin
        ready_nx  = 1'b1;
        result_nx = bus.result_o;
      end else state_nx = FREE;
      default: state_nx = FREE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= FREE;
    else state <= state_nx;
  // datapath and output registers; reset clears any partial result
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt          <= '0;
      dvd          <= '0;
      dvr          <= '0;
      rem          <= '0;
      neg1         <= 1'b0;
      neg2         <= 1'b0;
      sgn          <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= 1'b0;
    end else begin
      cnt          <= cnt_nx;
      dvd          <= dvd_nx;
      dvr          <= dvr_nx;
      rem          <= rem_nx;
      neg1         <= neg1_nx;
      neg2         <= neg2_nx;
      sgn          <= sgn_nx;
      bus.result_o <= result_nx;
      bus.ready_o  <= ready_nx;
    end
endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed self-checking bench for ex_div
module tb_ex_div;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n = 0;
  int   nf = 0;
  ex_div_if #(.DW(32)) bus ();
  ex_div #(.DW(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int edges, output logic [63:0] res);
    @(negedge clk);
    bus.start_i = 1'b1; bus.signed_i = s; bus.opdata1_i = a; bus.opdata2_i = b; bus.annul_i = 1'b0;
    edges = 0; res = '0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.ready_o) begin edges = i; res = bus.result_o; break; end
    end
  endtask

  task automatic drop();
    @(negedge clk); bus.start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    n++; if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0 || bus.stallreq_o !== 1'b0) begin
      nf++; $display("FAIL reset: ready=%b result=%h stall=%b want 0/0/0", bus.ready_o, bus.result_o, bus.stallreq_o);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_unsigned();
    logic exp_rdy;
    @(negedge clk);
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7; bus.annul_i = 1'b0;
    #1;
    n++; if (bus.stallreq_o !== 1'b1) begin nf++; $display("FAIL unsigned_stall_e0: stall=%b want 1", bus.stallreq_o); end
    for (int i = 1; i <= 33; i++) begin
      @(posedge clk); #1;
      exp_rdy = (i == 33);
      n++; if (bus.ready_o !== exp_rdy || bus.stallreq_o !== !exp_rdy) begin
        nf++; $display("FAIL unsigned_timing edge %0d: ready=%b stall=%b want %b/%b", i, bus.ready_o, bus.stallreq_o, exp_rdy, !exp_rdy);
      end
    end
    n++; if (bus.result_o !== 64'h00000002_0000000E) begin nf++; $display("FAIL unsigned_result: got %h want %h", bus.result_o, 64'h00000002_0000000E); end
    drop();
    n++; if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin nf++; $display("FAIL unsigned_drop: ready=%b result=%h want 0/0", bus.ready_o, bus.result_o); end
  endtask

  task automatic test_signed();
    int e; logic [63:0] r;
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, e, r);
    n++; if (e !== 33 || r !== 64'hFFFFFFFF_FFFFFFFD) begin nf++; $display("FAIL signed_neg_dvd: edges=%0d result=%h want 33 %h", e, r, 64'hFFFFFFFF_FFFFFFFD); end
    drop();
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, e, r);
    n++; if (e !== 33 || r !== 64'h00000001_FFFFFFFD) begin nf++; $display("FAIL signed_neg_dvr: edges=%0d result=%h want 33 %h", e, r, 64'h00000001_FFFFFFFD); end
    drop();
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, e, r);
    n++; if (r !== 64'h00000000_80000000) begin nf++; $display("FAIL signed_overflow: result=%h want %h", r, 64'h00000000_80000000); end
    drop();
  endtask

  task automatic test_by_zero();
    int e; logic [63:0] r;
    run_div(1'b0, 32'd5, 32'd0, e, r);
    n++; if (e !== 2 || r !== 64'h0) begin nf++; $display("FAIL by_zero: edges=%0d result=%h want 2 0", e, r); end
    drop();
    n++; if (bus.ready_o !== 1'b0) begin nf++; $display("FAIL by_zero_drop: ready=%b want 0", bus.ready_o); end
  endtask

  task automatic test_annul();
    int e; logic [63:0] r; logic seen;
    @(negedge clk);
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3;
    repeat (10) @(posedge clk);
    @(negedge clk); bus.annul_i = 1'b1;
    @(negedge clk); bus.annul_i = 1'b0; bus.start_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen |= bus.ready_o; end
    n++; if (seen !== 1'b0) begin nf++; $display("FAIL annul_no_ready: ready seen=%b want 0", seen); end
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, e, r);
    n++; if (e !== 33 || r !== 64'h00000000_FFFFFFFF) begin nf++; $display("FAIL annul_restart: edges=%0d result=%h want 33 %h", e, r, 64'h00000000_FFFFFFFF); end
    drop();
  endtask

  task automatic test_start_annul_free();
    int e;
    @(negedge clk);
    bus.start_i = 1'b1; bus.annul_i = 1'b1; bus.signed_i = 1'b0; bus.opdata1_i = 32'd20; bus.opdata2_i = 32'd4;
    #1;
    n++; if (bus.stallreq_o !== 1'b0) begin nf++; $display("FAIL start_annul_stall: stall=%b want 0", bus.stallreq_o); end
    repeat (3) @(posedge clk);
    @(negedge clk); bus.annul_i = 1'b0;
    e = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.ready_o) begin e = i; break; end
    end
    n++; if (e !== 33 || bus.result_o !== 64'h00000000_00000005) begin nf++; $display("FAIL start_annul_free: edges=%0d result=%h want 33 %h", e, bus.result_o, 64'h5); end
    drop();
  endtask

  task automatic test_held_start();
    int e; logic bad;
    @(negedge clk);
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3;
    repeat (5) @(posedge clk);
    @(negedge clk); bus.opdata1_i = 32'd7; bus.opdata2_i = 32'd0; bus.signed_i = 1'b1;
    e = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.ready_o) begin e = i; break; end
    end
    n++; if (e === 0 || bus.result_o !== 64'h00000001_0000014D) begin nf++; $display("FAIL operand_change: result=%h want %h", bus.result_o, 64'h00000001_0000014D); end
    bad = 1'b0;
    repeat (5) begin @(posedge clk); #1; bad |= (bus.ready_o !== 1'b1) || (bus.result_o !== 64'h00000001_0000014D); end
    n++; if (bad !== 1'b0) begin nf++; $display("FAIL held_start: ready=%b result=%h want 1 %h", bus.ready_o, bus.result_o, 64'h00000001_0000014D); end
    drop();
    n++; if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin nf++; $display("FAIL held_drop: ready=%b result=%h want 0/0", bus.ready_o, bus.result_o); end
    bus.signed_i = 1'b0;
  endtask

  task automatic test_async_reset();
    int e; logic [63:0] r; logic seen;
    @(negedge clk);
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.opdata1_i = 32'h12345678; bus.opdata2_i = 32'h10;
    repeat (15) @(posedge clk);
    #2 rst = 1'b0; bus.start_i = 1'b0;
    #1;
    n++; if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin nf++; $display("FAIL reset_mid: ready=%b result=%h want 0/0", bus.ready_o, bus.result_o); end
    @(negedge clk); rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen |= bus.ready_o; end
    n++; if (seen !== 1'b0) begin nf++; $display("FAIL reset_abort: ready seen=%b want 0", seen); end
    run_div(1'b0, 32'h12345678, 32'h10, e, r);
    n++; if (e !== 33 || r !== 64'h00000008_01234567) begin nf++; $display("FAIL reset_restart: edges=%0d result=%h want 33 %h", e, r, 64'h00000008_01234567); end
    #1 rst = 1'b0;
    #1;
    n++; if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin nf++; $display("FAIL reset_async_end: ready=%b result=%h want 0/0", bus.ready_o, bus.result_o); end
    bus.start_i = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    bus.start_i = 1'b0; bus.signed_i = 1'b0; bus.opdata1_i = '0; bus.opdata2_i = '0; bus.annul_i = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_by_zero();
    test_annul();
    test_start_annul_free();
    test_held_start();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n, nf);
    $finish;
  end
endmodule
